// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with saturating counters for IF prediction, plus EX-stage target
// resolution and a registered mispredict redirect. Optional counters: BPU_STATS_EN.
module branch_predict_unit #(
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = 30 - IDX_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc_plus_4,
   input  logic        ex_is_branch,
   input  logic        ex_is_jump,
   input  logic        ex_cond_true,
   input  logic [31:0] ex_imm,
   input  logic [25:0] ex_instr_index,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        redirect,
   output logic [31:0] redirect_pc
`ifdef BPU_STATS_EN
   ,
   output logic [31:0] stat_resolved,
   output logic [31:0] stat_mispredict
`endif
);

   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

   logic [ENTRIES-1:0] valid_q;
   logic [CTR_W-1:0]   ctr_q [ENTRIES];
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];

   // Fetch-side lookup reads only registered state, so an update in the same cycle is not seen.
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx      = if_pc[IDX_W+1:2];
   assign if_tag      = if_pc[31:IDX_W+2];
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_valid && if_hit && ctr_q[if_idx][CTR_W-1];
   assign pred_target = pred_taken ? tgt_q[if_idx] : (if_pc + 32'd4);

   logic [31:0]      ex_pc;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic [31:0]      target;
   logic             taken;
   logic [31:0]      actual;
   logic             mispredict;
   logic             accept;

   assign ex_pc      = ex_pc_plus_4 - 32'd4;
   assign ex_idx     = ex_pc[IDX_W+1:2];
   assign ex_tag     = ex_pc[31:IDX_W+2];
   assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign target     = ex_is_jump ? {ex_pc_plus_4[31:28], ex_instr_index, 2'b00}
                                  : ex_pc_plus_4 + {ex_imm[29:0], 2'b00};
   assign taken      = ex_is_jump || (ex_is_branch && ex_cond_true);
   assign actual     = taken ? target : ex_pc_plus_4;
   assign mispredict = (ex_pred_taken != taken) || (taken && (ex_pred_target != target));
   // The instruction in EX during a redirect cycle is on the wrong path.
   assign accept     = ex_valid && !redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         redirect    <= 1'b0;
         redirect_pc <= 32'd0;
         for (int k = 0; k < ENTRIES; k++) ctr_q[k] <= '0;
      end else begin
         redirect <= accept && mispredict;
         if (accept && mispredict) redirect_pc <= actual;
         if (accept) begin
            if (ex_is_jump) begin
               valid_q[ex_idx] <= 1'b1;
               ctr_q[ex_idx]   <= CTR_MAX;
            end else if (ex_is_branch) begin
               if (ex_hit) begin
                  if (taken && ctr_q[ex_idx] != CTR_MAX)
                     ctr_q[ex_idx] <= ctr_q[ex_idx] + 1'b1;
                  else if (!taken && ctr_q[ex_idx] != '0)
                     ctr_q[ex_idx] <= ctr_q[ex_idx] - 1'b1;
               end else if (taken) begin
                  valid_q[ex_idx] <= 1'b1;
                  ctr_q[ex_idx]   <= CTR_WEAK;
               end
            end else if (ex_pred_taken) begin
               // A non-control instruction predicted taken means the entry aliases; drop it.
               valid_q[ex_idx] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && (ex_is_jump || (ex_is_branch && taken))) begin
         tag_q[ex_idx] <= ex_tag;
         tgt_q[ex_idx] <= target;
      end
   end

`ifdef BPU_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_resolved   <= 32'd0;
         stat_mispredict <= 32'd0;
      end else begin
         if (accept && (ex_is_branch || ex_is_jump)) stat_resolved <= stat_resolved + 32'd1;
         if (accept && mispredict) stat_mispredict <= stat_mispredict + 32'd1;
      end
   end
`endif

   logic unused_bits;
   assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], ex_imm[31:30]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: reset, allocation, jumps, counter saturation,
// alias invalidation, redirect-shadow squash and asynchronous reset.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc_plus_4;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic        ex_cond_true;
   logic [31:0] ex_imm;
   logic [25:0] ex_instr_index;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef BPU_STATS_EN
   logic [31:0] stat_resolved;
   logic [31:0] stat_mispredict;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_predict_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_pc_plus_4   (ex_pc_plus_4),
      .ex_is_branch   (ex_is_branch),
      .ex_is_jump     (ex_is_jump),
      .ex_cond_true   (ex_cond_true),
      .ex_imm         (ex_imm),
      .ex_instr_index (ex_instr_index),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc)
`ifdef BPU_STATS_EN
      ,
      .stat_resolved  (stat_resolved),
      .stat_mispredict(stat_mispredict)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_ex(input logic [31:0] pc4, input logic br, input logic jp, input logic cond,
                         input logic [31:0] imm, input logic [25:0] idx,
                         input logic pt, input logic [31:0] ptgt);
      ex_valid       = 1'b1;
      ex_pc_plus_4   = pc4;
      ex_is_branch   = br;
      ex_is_jump     = jp;
      ex_cond_true   = cond;
      ex_imm         = imm;
      ex_instr_index = idx;
      ex_pred_taken  = pt;
      ex_pred_target = ptgt;
   endtask

   task automatic go();
      @(posedge clk);
      #1;
      ex_valid      = 1'b0;
      ex_is_branch  = 1'b0;
      ex_is_jump    = 1'b0;
      ex_pred_taken = 1'b0;
   endtask

   task automatic resolve(input logic [31:0] pc4, input logic br, input logic jp, input logic cond,
                          input logic [31:0] imm, input logic [25:0] idx,
                          input logic pt, input logic [31:0] ptgt);
      set_ex(pc4, br, jp, cond, imm, idx, pt, ptgt);
      go();
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
      if_valid = 1'b1;
      if_pc    = pc;
      #1;
      check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
      check({tag, "_target"}, pred_target, tgt);
   endtask

   task automatic check_redirect(input string tag, input logic r, input logic [31:0] pc);
      check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, r});
      check({tag, "_redirect_pc"}, redirect_pc, pc);
   endtask

   initial begin
      rst_n = 1'b0;
      if_valid = 1'b0; if_pc = 32'd0;
      ex_valid = 1'b0; ex_pc_plus_4 = 32'd0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
      ex_cond_true = 1'b0; ex_imm = 32'd0; ex_instr_index = 26'd0;
      ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
      #12 rst_n = 1'b1;
      idle();

      check_redirect("reset", 1'b0, 32'd0);
      lookup("reset", 32'h1000_0000, 1'b0, 32'h1000_0004);

      // Taken branch on a cold BTB; lookup of the same index in the same cycle sees the old miss
      set_ex(32'h1000_0004, 1'b1, 1'b0, 1'b1, 32'd1, 26'd0, 1'b0, 32'd0);
      lookup("no_bypass", 32'h1000_0000, 1'b0, 32'h1000_0004);
      go();
      check_redirect("br_alloc", 1'b1, 32'h1000_0008);
      idle();
      check_redirect("br_alloc_next", 1'b0, 32'h1000_0008);
      lookup("br_alloc", 32'h1000_0000, 1'b1, 32'h1000_0008);

      resolve(32'h7000_0000, 1'b0, 1'b1, 1'b0, 32'd0, 26'h1, 1'b0, 32'd0);
      check_redirect("jump", 1'b1, 32'h7000_0004);
      idle();
      lookup("jump", 32'h6FFF_FFFC, 1'b1, 32'h7000_0004);

      // Counter walk: 2 -> 1 (mispredict) -> 0 -> 0 (saturate) -> 1 -> 2
      resolve(32'h1000_0004, 1'b1, 1'b0, 1'b0, 32'd1, 26'd0, 1'b1, 32'h1000_0008);
      check_redirect("ctr_nt", 1'b1, 32'h1000_0004);
      idle();
      lookup("ctr1", 32'h1000_0000, 1'b0, 32'h1000_0004);
      resolve(32'h1000_0004, 1'b1, 1'b0, 1'b0, 32'd1, 26'd0, 1'b0, 32'd0);
      check_redirect("ctr_nt2", 1'b0, 32'h1000_0004);
      resolve(32'h1000_0004, 1'b1, 1'b0, 1'b0, 32'd1, 26'd0, 1'b0, 32'd0);
      check_redirect("ctr_nt3", 1'b0, 32'h1000_0004);
      lookup("ctr0", 32'h1000_0000, 1'b0, 32'h1000_0004);
      resolve(32'h1000_0004, 1'b1, 1'b0, 1'b1, 32'd1, 26'd0, 1'b0, 32'd0);
      check_redirect("ctr_t1", 1'b1, 32'h1000_0008);
      idle();
      lookup("ctr_sat", 32'h1000_0000, 1'b0, 32'h1000_0004);
      resolve(32'h1000_0004, 1'b1, 1'b0, 1'b1, 32'd1, 26'd0, 1'b0, 32'd0);
      idle();
      lookup("ctr2", 32'h1000_0000, 1'b1, 32'h1000_0008);

      // Alias: same index, different tag, then non-branch predicted taken
      lookup("alias_miss", 32'h1000_0040, 1'b0, 32'h1000_0044);
      resolve(32'h1000_0004, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 1'b1, 32'h1000_0008);
      check_redirect("alias", 1'b1, 32'h1000_0004);
      // Mispredicting jump in the redirect shadow must be squashed
      resolve(32'h2000_0000, 1'b0, 1'b1, 1'b0, 32'd0, 26'h5, 1'b0, 32'd0);
      check_redirect("squash", 1'b0, 32'h1000_0004);
      lookup("alias_inval", 32'h1000_0000, 1'b0, 32'h1000_0004);
      lookup("squash_nowrite", 32'h1FFF_FFFC, 1'b0, 32'h2000_0000);
      lookup("jump_kept", 32'h6FFF_FFFC, 1'b1, 32'h7000_0004);

      // Asynchronous reset while a redirect is pending
      resolve(32'h3000_0000, 1'b0, 1'b1, 1'b0, 32'd0, 26'h2, 1'b0, 32'd0);
      check_redirect("pre_areset", 1'b1, 32'h3000_0008);
      #2 rst_n = 1'b0;
      #1;
      check_redirect("areset", 1'b0, 32'd0);
      lookup("areset_jump", 32'h6FFF_FFFC, 1'b0, 32'h7000_0000);
      #2 rst_n = 1'b1;
      idle();
      check_redirect("post_areset", 1'b0, 32'd0);
      lookup("post_areset", 32'h2FFF_FFFC, 1'b0, 32'h3000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised next-generation branch/jump target unit for the 5-stage MIPS pipeline.
- Holds a direct-mapped branch target buffer (BTB) with saturating counters, used by IF to predict the next PC.
- In EX it computes the actual target: branch = PC+4 + (imm<<2); J-type = {PC+4[31:28], index, 2'b00}.
- On a mispredict it issues a registered redirect to the fetch mux.

Parameters:
- ENTRIES, 16: BTB entries; power of two, 2..256. IDX_W = $clog2(ENTRIES).
- CTR_W, 2: saturating counter width, 1..4. Predict taken when counter MSB = 1.
- TAG_W, 30-IDX_W: tag width, equal to PC bits [31:IDX_W+2]. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch lookup valid
- if_pc  in  32  fetch PC, word aligned
- pred_taken  out  1  combinational prediction for if_pc
- pred_target  out  32  combinational predicted next PC
- ex_valid  in  1  instruction in EX valid
- ex_pc_plus_4  in  32  PC+4 of EX instruction
- ex_is_branch  in  1  conditional branch
- ex_is_jump  in  1  J/JAL
- ex_cond_true  in  1  branch condition outcome
- ex_imm  in  32  sign-extended immediate
- ex_instr_index  in  26  instr[25:0]
- ex_pred_taken  in  1  pred_taken piped from IF
- ex_pred_target  in  32  pred_target piped from IF
- redirect  out  1  registered mispredict flush
- redirect_pc  out  32  registered correct next PC

Behaviour:
- Reset (async, rst_n=0): all valid bits, counters, redirect and redirect_pc cleared to 0. Tag/target arrays need no reset. Deassertion is sampled synchronously.
- Lookup (combinational from registered arrays):
  - i = if_pc[IDX_W+1:2]; hit = valid[i] & tag[i]==if_pc[31:IDX_W+2].
  - pred_taken = if_valid & hit & ctr[i][CTR_W-1].
  - pred_target = pred_taken ? tgt[i] : if_pc+4 (mod 2^32).
- Resolve (combinational in EX, applied at the clock edge):
  - pc = ex_pc_plus_4-4; j = pc[IDX_W+1:2].
  - target = is_jump ? {pc4[31:28], ex_instr_index, 2'b00} : pc4 + (ex_imm<<2), truncated to 32 bits, wrap allowed.
  - taken = is_jump | (is_branch & cond_true); actual = taken ? target : pc4.
  - mispredict = ex_pred_taken!=taken | (taken & ex_pred_target!=target).
- Redirect: one cycle after an accepted EX with mispredict, redirect=1 and redirect_pc=actual. Otherwise redirect=0 and redirect_pc holds its last value.
- Shadow squash: while redirect=1, ex_valid is ignored (wrong-path instruction). No update, no redirect.
- Update (accepted ex_valid, no squash):
  - Jump: write tag/tgt, valid=1, ctr=all ones.
  - Branch, hit: tgt=target if taken. Ctr +1 if taken, -1 if not taken, saturating at all-ones and 0.
  - Branch, miss, taken: allocate with ctr = 2^(CTR_W-1) (weakly taken).
  - Branch, miss, not taken: no allocation.
  - Non-branch with ex_pred_taken=1 (alias): valid[j] cleared; redirect to pc4.
- Same-cycle lookup and update of the same index: lookup sees old contents (no bypass).
- Reset mid-operation: pending redirect dropped, BTB invalidated immediately.

Optional Feature:
- BPU_STATS_EN defined: adds outputs stat_resolved[31:0] and stat_mispredict[31:0].
  - Reset to 0; count accepted branch/jump resolutions and redirects; wrap at 2^32.
- Undefined: ports and counters absent; remaining behaviour identical.

Test Plan:
- Reset: rst_n=0 then 1; if_valid=1, if_pc=0x10000000 -> pred_taken=0, pred_target=0x10000004, redirect=0.
- Branch mispredict: ex_pc_plus_4=0x10000004, imm=1, is_branch=1, cond_true=1, pred_taken=0 -> next cycle redirect=1, redirect_pc=0x10000008. Then lookup 0x10000000 -> pred_taken=1, pred_target=0x10000008.
- Jump: ex_pc_plus_4=0x70000000, instr_index=0x0000001, is_jump=1, pred_taken=0 -> redirect_pc=0x70000004. Lookup 0x6FFFFFFC -> taken, 0x70000004.
- Counter: the branch above resolved not taken with pred_taken=1 -> redirect_pc=0x10000004, ctr=1. Lookup 0x10000000 -> pred_taken=0. Two more not-taken resolutions -> ctr saturates at 0.
- Alias/squash: lookup 0x10000040 -> miss, pred_target=0x10000044. Non-branch at pc4=0x10000004 with pred_taken=1 -> redirect to 0x10000004 and entry 0 invalidated. A second mispredict in the following (redirect) cycle is ignored.
- Async reset: assert rst_n low mid-cycle while a redirect is pending -> redirect=0 immediately; all lookups miss afterwards.
